// File: rtl/ysyx_22040895_lsu.sv
// Load/store unit: one operation at a time through an IDLE -> REQ -> WAIT bus handshake.
// Define YSYX_22040895_LSU_MISALIGN_TRAP_EN to report misaligned accesses instead of aligning them down.
module ysyx_22040895_lsu #(
    parameter int XLEN = 64,
    parameter int OFFW = $clog2(XLEN/8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              ld_i,
    input  logic              st_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [XLEN-1:0]   result_i,
    input  logic [XLEN-1:0]   wmdata_i,
    output logic              resp_valid_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              misalign_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic [XLEN/8-1:0] mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);
    localparam int SW = XLEN / 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0]      r_state;
    logic            r_is_ld;
    logic            r_unsigned;
    logic [1:0]      r_size;
    logic [OFFW-1:0] r_off;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic [SW-1:0]   r_mem_wstrb;
    logic            r_resp_valid;
    logic            r_misalign;
    logic [XLEN-1:0] r_wdata;

    logic            w_accept;
    logic            w_mem_op;
    logic            w_trap;
    logic [OFFW-1:0] w_off;
    logic [OFFW-1:0] w_align_mask;
    logic [OFFW-1:0] w_off_eff;
    logic [SW-1:0]   w_strb_base;
    logic [XLEN-1:0] w_rd_shifted;
    logic [XLEN-1:0] w_lane_mask;
    logic            w_sign_bit;
    logic [XLEN-1:0] w_ld_data;

    // Ready is gated by reset so the pipeline never sees a handshake while the unit is held.
    assign req_ready_o  = rst & (r_state == S_IDLE);
    assign w_accept     = req_valid_i & req_ready_o;
    assign w_mem_op     = ld_i | st_i;
    assign w_off        = result_i[OFFW-1:0];
    assign w_align_mask = OFFW'((4'd1 << size_i) - 4'd1);

`ifdef YSYX_22040895_LSU_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = ((w_off & w_align_mask) != '0) || ((XLEN == 32) && (size_i == 2'b11));
    assign w_trap     = w_misalign & w_mem_op;
    assign w_off_eff  = w_off;
`else
    assign w_trap     = 1'b0;
    assign w_off_eff  = w_off & ~w_align_mask;
`endif

    always_comb begin
        case (size_i)
            2'b00:   w_strb_base = SW'(8'h01);
            2'b01:   w_strb_base = SW'(8'h03);
            2'b10:   w_strb_base = SW'(8'h0F);
            default: w_strb_base = SW'(8'hFF);
        endcase
    end

    // Load lane extraction uses the size/offset captured at accept time.
    always_comb begin
        w_rd_shifted = mem_rdata_i >> {r_off, 3'b000};
        case (r_size)
            2'b00: begin
                w_lane_mask = XLEN'(8'hFF);
                w_sign_bit  = w_rd_shifted[7];
            end
            2'b01: begin
                w_lane_mask = XLEN'(16'hFFFF);
                w_sign_bit  = w_rd_shifted[15];
            end
            2'b10: begin
                w_lane_mask = XLEN'(32'hFFFF_FFFF);
                w_sign_bit  = w_rd_shifted[31];
            end
            default: begin
                w_lane_mask = '1;
                w_sign_bit  = 1'b0;
            end
        endcase
        w_ld_data = (w_rd_shifted & w_lane_mask) | ((w_sign_bit & ~r_unsigned) ? ~w_lane_mask : '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_is_ld      <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
            r_resp_valid <= 1'b0;
            r_misalign   <= 1'b0;
            r_wdata      <= '0;
        end else begin
            // NOTE: response flags default low every cycle so each response is a single-cycle pulse.
            r_resp_valid <= 1'b0;
            r_misalign   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!w_mem_op) begin
                            r_resp_valid <= 1'b1;
                            r_wdata      <= result_i;
                        end else if (w_trap) begin
                            r_resp_valid <= 1'b1;
                            r_misalign   <= 1'b1;
                            r_wdata      <= '0;
                        end else begin
                            r_state     <= S_REQ;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= st_i & ~ld_i;
                            r_mem_addr  <= {result_i[XLEN-1:OFFW], {OFFW{1'b0}}};
                            r_mem_wdata <= ld_i ? '0 : (wmdata_i << {w_off_eff, 3'b000});
                            r_mem_wstrb <= ld_i ? '0 : (w_strb_base << w_off_eff);
                            r_is_ld     <= ld_i;
                            r_unsigned  <= unsigned_i;
                            r_size      <= size_i;
                            r_off       <= w_off_eff;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        r_state   <= S_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b1;
                        r_wdata      <= r_is_ld ? w_ld_data : '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_valid_o = r_resp_valid;
    assign wdata_o      = r_wdata;
    assign misalign_o   = r_misalign;
    assign mem_req_o    = r_mem_req;
    assign mem_we_o     = r_mem_we;
    assign mem_addr_o   = r_mem_addr;
    assign mem_wdata_o  = r_mem_wdata;
    assign mem_wstrb_o  = r_mem_wstrb;
endmodule
